// File: rtl/noc_out_arbiter_pkg.sv
// noc_pkg: shared constants, FSM state type and flit-width helper for the
// NoC output-port arbiter and its neighbouring switch blocks.
// Configuration macro: NOC_ARB_RR_EN (round-robin when defined, fixed
// priority bottom > left > PE otherwise).
package noc_pkg;

  localparam int REQ_L   = 0;
  localparam int REQ_B   = 1;
  localparam int REQ_PE  = 2;
  localparam int NUM_REQ = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Flit width shared with the switches: two x fields, two y fields, payload.
  function automatic int flit_width(input int x_size, input int y_size, input int data_width);
    return 2 * x_size + 2 * y_size + data_width;
  endfunction

endpackage

// File: rtl/noc_out_arbiter_if.sv
// Handshake bundle between three requesters, the output-port arbiter and the
// downstream switch. The master modport is the arbiter's view; slave is the
// view of whoever drives requests and consumes the output flit.
// Configuration macro used by the arbiter: NOC_ARB_RR_EN.
interface noc_out_arbiter_if
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int X_SIZE      = 2,
  parameter int Y_SIZE      = 2,
  parameter int TOTAL_WIDTH = flit_width(X_SIZE, Y_SIZE, DATA_WIDTH)
);
  logic                   i_valid_l;
  logic                   i_valid_b;
  logic                   i_valid_pe;
  logic [TOTAL_WIDTH-1:0] i_data_l;
  logic [TOTAL_WIDTH-1:0] i_data_b;
  logic [TOTAL_WIDTH-1:0] i_data_pe;
  logic                   o_ready_l;
  logic                   o_ready_b;
  logic                   o_ready_pe;
  logic                   o_valid;
  logic [TOTAL_WIDTH-1:0] o_data;
  logic                   i_ready;
  logic [2:0]             o_grant;

  modport master (
    input  i_valid_l, i_valid_b, i_valid_pe,
    input  i_data_l, i_data_b, i_data_pe,
    input  i_ready,
    output o_ready_l, o_ready_b, o_ready_pe,
    output o_valid, o_data, o_grant
  );

  modport slave (
    output i_valid_l, i_valid_b, i_valid_pe,
    output i_data_l, i_data_b, i_data_pe,
    output i_ready,
    input  o_ready_l, o_ready_b, o_ready_pe,
    input  o_valid, o_data, o_grant
  );

endinterface

// File: rtl/noc_out_arbiter_chk.sv
// Property checker for the output-port arbiter: grant shape, grant only to
// valid requesters, and output flit held while stalled.
module noc_out_arbiter_chk #(
  parameter int TOTAL_WIDTH = 16
)(
  input logic                   clk,
  input logic                   rstn,
  input logic [2:0]             valid,
  input logic [2:0]             grant,
  input logic                   o_valid,
  input logic                   i_ready,
  input logic [TOTAL_WIDTH-1:0] o_data
);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(grant));

  a_grant_valid: assert property (@(posedge clk) disable iff (!rstn)
    (grant & ~valid) == 3'b000);

  a_data_stable: assert property (@(posedge clk) disable iff (!rstn)
    (o_valid && !i_ready) |=> $stable(o_data));

endmodule

// File: rtl/noc_out_arbiter_rr_arbiter.sv
// Combinational three-way rotating-priority arbiter. ptr names the requester
// with the highest priority; the search then continues in index order with
// wrap-around. Returns a one-hot grant, or zero when nothing is requested.
module noc_rr_arbiter
  import noc_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant
);

  // Pick the first active request starting at the pointer position.
  always_comb begin
    grant = 3'b000;
    case (ptr)
      2'd0: begin
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else             grant = 3'b000;
      end
      2'd1: begin
        if (req[1])      grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else             grant = 3'b000;
      end
      2'd2: begin
        if (req[2])      grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else             grant = 3'b000;
      end
      default: grant = 3'b000;
    endcase
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// NoC output-port arbiter: selects one of left/bottom/PE flits whenever the
// output register can load, and holds the chosen flit for the downstream
// switch until it is accepted. Header bits are never inspected.
// Configuration macro: NOC_ARB_RR_EN -- defined gives round-robin L->B->PE,
// undefined gives fixed priority bottom > left > PE with no pointer state.
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int X_SIZE      = 2,
  parameter int Y_SIZE      = 2,
  parameter int TOTAL_WIDTH = flit_width(X_SIZE, Y_SIZE, DATA_WIDTH)
)(
  input  logic             clk,
  input  logic             rstn,
  noc_out_arbiter_if.master bus
);

  logic                   load_s;
  logic [NUM_REQ-1:0]     req_s;
  logic [NUM_REQ-1:0]     arb_grant_s;
  logic [NUM_REQ-1:0]     grant_s;
  logic [TOTAL_WIDTH-1:0] sel_data_s;
  state_t                 state_r;
  logic                   o_valid_r;
  logic [TOTAL_WIDTH-1:0] o_data_r;

  assign req_s  = {bus.i_valid_pe, bus.i_valid_b, bus.i_valid_l};
  assign load_s = ~o_valid_r | bus.i_ready;

`ifdef NOC_ARB_RR_EN
  logic [1:0] ptr_r;

  noc_rr_arbiter u_arb (
    .req   (req_s),
    .ptr   (ptr_r),
    .grant (arb_grant_s)
  );

  // Move the priority pointer to the requester after the one just accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_r <= 2'd0;
    end else begin
      case (grant_s)
        3'b001:  ptr_r <= 2'd1;
        3'b010:  ptr_r <= 2'd2;
        3'b100:  ptr_r <= 2'd0;
        default: ptr_r <= ptr_r;
      endcase
    end
  end
`else
  // Fixed priority reuses the rotating arbiter with a frozen pointer and the
  // requests reordered as slot0=bottom, slot1=left, slot2=PE.
  logic [NUM_REQ-1:0] perm_grant_s;

  noc_rr_arbiter u_arb (
    .req   ({req_s[REQ_PE], req_s[REQ_L], req_s[REQ_B]}),
    .ptr   (2'd0),
    .grant (perm_grant_s)
  );

  assign arb_grant_s = {perm_grant_s[2], perm_grant_s[0], perm_grant_s[1]};
`endif

  // Grant only while the output register can load and reset is released.
  always_comb begin
    grant_s = 3'b000;
    if (rstn && load_s) begin
      grant_s = arb_grant_s;
    end else begin
      grant_s = 3'b000;
    end
  end

  // Route the granted requester's flit towards the output register.
  always_comb begin
    sel_data_s = {TOTAL_WIDTH{1'b0}};
    case (grant_s)
      3'b001:  sel_data_s = bus.i_data_l;
      3'b010:  sel_data_s = bus.i_data_b;
      3'b100:  sel_data_s = bus.i_data_pe;
      default: sel_data_s = {TOTAL_WIDTH{1'b0}};
    endcase
  end

  // Output-register FSM: EMPTY fills on a grant, FULL drains on accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= EMPTY;
      o_valid_r <= 1'b0;
      o_data_r  <= {TOTAL_WIDTH{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (|grant_s) begin
            state_r   <= FULL;
            o_valid_r <= 1'b1;
            o_data_r  <= sel_data_s;
          end
        end
        FULL: begin
          if (|grant_s) begin
            o_data_r <= sel_data_s;
          end else if (bus.i_ready) begin
            state_r   <= EMPTY;
            o_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= EMPTY;
          o_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_grant    = grant_s;
  assign bus.o_ready_l  = grant_s[REQ_L];
  assign bus.o_ready_b  = grant_s[REQ_B];
  assign bus.o_ready_pe = grant_s[REQ_PE];
  assign bus.o_valid    = o_valid_r;
  assign bus.o_data     = o_data_r;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Randomised self-checking bench for noc_out_arbiter with a queue-based
// reference model and a flit scoreboard.
module tb_noc_out_arbiter;
  import noc_pkg::*;

  localparam int TW = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  noc_out_arbiter_if #(.DATA_WIDTH(8), .X_SIZE(2), .Y_SIZE(2), .TOTAL_WIDTH(TW)) bus ();

  noc_out_arbiter #(.DATA_WIDTH(8), .X_SIZE(2), .Y_SIZE(2), .TOTAL_WIDTH(TW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  noc_out_arbiter_chk #(.TOTAL_WIDTH(TW)) chk (
    .clk     (clk),
    .rstn    (rstn),
    .valid   ({bus.i_valid_pe, bus.i_valid_b, bus.i_valid_l}),
    .grant   (bus.o_grant),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready),
    .o_data  (bus.o_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          exp_valid;
  logic [TW-1:0] exp_data;
  int          exp_ptr;
  logic [TW-1:0] sb_q[$];
  bit          pend[3];
  logic [TW-1:0] pdata[3];

  function automatic logic [2:0] exp_grant(input logic [2:0] v, input bit load, input int ptr);
    logic [2:0] g;
    int order[3];
    g = 3'b000;
    if (load) begin
`ifdef NOC_ARB_RR_EN
      order = '{ptr % 3, (ptr + 1) % 3, (ptr + 2) % 3};
`else
      order = '{1, 0, 2};
`endif
      for (int k = 0; k < 3; k++)
        if (g == 3'b000 && v[order[k]]) g[order[k]] = 1'b1;
    end
    return g;
  endfunction

  task automatic apply_inputs();
    bus.i_valid_l  = pend[0];
    bus.i_valid_b  = pend[1];
    bus.i_valid_pe = pend[2];
    bus.i_data_l   = pdata[0];
    bus.i_data_b   = pdata[1];
    bus.i_data_pe  = pdata[2];
  endtask

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_ptr   = 0;
    sb_q.delete();
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < 3; i++)
      if (!pend[i] && $urandom_range(99) < pct) begin
        pend[i]  = 1'b1;
        pdata[i] = TW'($urandom);
      end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; pdata[i] = '0; end
    apply_inputs();
    bus.i_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus and checking; called just after a falling edge.
  task automatic run_cycle(input string tag, output logic [2:0] obs_grant);
    logic [2:0] v;
    logic [2:0] eg;
    logic [TW-1:0] want;
    int idx;
    apply_inputs();
    #1;
    v  = {pend[2], pend[1], pend[0]};
    eg = exp_grant(v, !exp_valid || bus.i_ready, exp_ptr);
    obs_grant = bus.o_grant;
    total++;
    if (bus.o_grant !== eg) begin
      bad++; $display("FAIL %s grant: got %b want %b", tag, bus.o_grant, eg);
    end
    total++;
    if ({bus.o_ready_pe, bus.o_ready_b, bus.o_ready_l} !== eg) begin
      bad++; $display("FAIL %s ready: got %b want %b", tag,
                      {bus.o_ready_pe, bus.o_ready_b, bus.o_ready_l}, eg);
    end
    if (exp_valid && bus.i_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++; $display("FAIL %s scoreboard: got extra flit %h want none", tag, bus.o_data);
      end else begin
        want = sb_q.pop_front();
        if (bus.o_data !== want) begin
          bad++; $display("FAIL %s delivered: got %h want %h", tag, bus.o_data, want);
        end
      end
    end
    if (eg != 3'b000) begin
      idx = eg[0] ? 0 : (eg[1] ? 1 : 2);
      exp_valid = 1'b1;
      exp_data  = pdata[idx];
      sb_q.push_back(pdata[idx]);
      exp_ptr   = (idx + 1) % 3;
      pend[idx] = 1'b0;
    end else if (bus.i_ready) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.o_valid !== exp_valid) begin
      bad++; $display("FAIL %s o_valid: got %b want %b", tag, bus.o_valid, exp_valid);
    end
    total++;
    if (bus.o_data !== exp_data) begin
      bad++; $display("FAIL %s o_data: got %h want %h", tag, bus.o_data, exp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] g;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin pend[i] = 1'b1; pdata[i] = TW'(16'h1111 * (i + 1)); end
    apply_inputs();
    bus.i_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset o_valid: got %b want 0", bus.o_valid); end
      total++;
      if (bus.o_data !== '0) begin bad++; $display("FAIL reset o_data: got %h want 0", bus.o_data); end
      total++;
      if (bus.o_grant !== 3'b000) begin bad++; $display("FAIL reset o_grant: got %b want 000", bus.o_grant); end
      @(negedge clk);
    end
    rstn = 1'b1;
    model_reset();
    run_cycle("reset_first", g);
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    run_cycle("reset_drain", g);
  endtask

  task automatic test_single();
    logic [2:0] g;
    do_reset();
    pend[0] = 1'b1; pdata[0] = 16'h02A5;
    bus.i_ready = 1'b1;
    run_cycle("single_c0", g);
    total++;
    if (g !== 3'b001) begin bad++; $display("FAIL single ready_l: got %b want 001", g); end
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 16'h02A5) begin
      bad++; $display("FAIL single c1: got v=%b d=%h want v=1 d=02a5", bus.o_valid, bus.o_data);
    end
    run_cycle("single_c1", g);
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL single c2 o_valid: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_all_valid();
    logic [2:0] g;
    logic [2:0] want;
    do_reset();
    bus.i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      refill(100);
      run_cycle("allv", g);
`ifdef NOC_ARB_RR_EN
      want = 3'(1 << (c % 3));
`else
      want = 3'b010;
`endif
      total++;
      if (g !== want) begin bad++; $display("FAIL allv order c%0d: got %b want %b", c, g, want); end
    end
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    run_cycle("allv_drain", g);
  endtask

  task automatic test_stall();
    logic [2:0] g;
    do_reset();
    bus.i_ready = 1'b1;
    pend[0] = 1'b1; pdata[0] = 16'hA001;
    run_cycle("stall_fill", g);
    bus.i_ready = 1'b0;
    refill(100);
    pend[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      run_cycle("stall_hold", g);
      total++;
      if (g !== 3'b000) begin bad++; $display("FAIL stall grant c%0d: got %b want 000", c, g); end
    end
    bus.i_ready = 1'b1;
    run_cycle("stall_release", g);
    total++;
    if (!$onehot(g)) begin bad++; $display("FAIL stall release grant: got %b want one-hot", g); end
    pend[0] = 1'b0; pend[2] = 1'b0;
    run_cycle("stall_drain", g);
  endtask

  task automatic test_reset_mid();
    logic [2:0] g;
    logic [2:0] want;
    do_reset();
    bus.i_ready = 1'b1;
    pend[0] = 1'b1; pdata[0] = 16'hBEEF;
    run_cycle("rmid_fill", g);
    bus.i_ready = 1'b0;
    pend[0] = 1'b1; pdata[0] = 16'h0C0C;
    apply_inputs();
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== '0) begin
      bad++; $display("FAIL rmid async: got v=%b d=%h want v=0 d=0", bus.o_valid, bus.o_data);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    refill(100);
    bus.i_ready = 1'b1;
    run_cycle("rmid_first", g);
`ifdef NOC_ARB_RR_EN
    want = 3'b001;
`else
    want = 3'b010;
`endif
    total++;
    if (g !== want) begin bad++; $display("FAIL rmid first grant: got %b want %b", g, want); end
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    run_cycle("rmid_drain", g);
  endtask

  task automatic test_random();
    logic [2:0] g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      refill(45);
      bus.i_ready = ($urandom_range(3) != 0);
      run_cycle("rand", g);
    end
    bus.i_ready = 1'b1;
    for (int c = 0; c < 20; c++) run_cycle("rand_drain", g);
    total++;
    if (sb_q.size() != 0 || pend[0] || pend[1] || pend[2]) begin
      bad++; $display("FAIL rand lost flits: got %0d queued want 0", sb_q.size());
    end
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rand final o_valid: got %b want 0", bus.o_valid); end
  endtask

  initial begin
    rstn = 1'b0;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; pdata[i] = '0; end
    apply_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_valid();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_out_arbiter.md
NOC_OUT_ARBITER -- requirements
Module: noc_out_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 Parameter X_SIZE, default 2, x-coordinate field width.
REQ-003 Parameter Y_SIZE, default 2, y-coordinate field width.
REQ-004 Parameter TOTAL_WIDTH, default 2*X_SIZE+2*Y_SIZE+DATA_WIDTH, flit width.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rstn  input  1  asynchronous, active-low reset.
REQ-007 i_valid_l / i_valid_b / i_valid_pe  input  1 each  left/bottom/PE requester holds a flit for this output port.
REQ-008 i_data_l / i_data_b / i_data_pe  input  TOTAL_WIDTH each  requester flits.
REQ-009 o_ready_l / o_ready_b / o_ready_pe  output  1 each  flit of that requester is accepted this cycle.
REQ-010 o_valid  output  1  output register holds a flit for the downstream switch.
REQ-011 o_data  output  TOTAL_WIDTH  registered flit.
REQ-012 i_ready  input  1  downstream accepts o_data this cycle.
REQ-013 o_grant  output  3  one-hot grant, bit0 left, bit1 bottom, bit2 PE; zero when nothing is granted.

Function
REQ-014 load = ~o_valid | i_ready; arbitration takes place only when load=1. When load=0, o_grant and all o_ready_* are 0.
REQ-015 o_grant is combinational: at most one bit is set, and only for a requester with valid=1. o_ready_x equals o_grant[x].
REQ-016 A requester transfers a flit when valid and ready are both 1. On the next edge o_data takes the granted flit and o_valid goes to 1. Latency is one cycle.
REQ-017 When o_valid=1 and i_ready=0, o_data and o_valid stay unchanged.
REQ-018 When o_valid=1, i_ready=1 and no requester is valid, o_valid goes to 0 on the next edge and o_data holds its value.
REQ-019 A two-state FSM tracks the output register. EMPTY goes to FULL on a grant. FULL goes to EMPTY on i_ready with no grant. FULL stays FULL on ~i_ready, or on i_ready with a grant.
REQ-020 Throughput: one flit per cycle while i_ready=1 and any requester is valid.
REQ-021 Round-robin: a priority pointer names the requester following the last one granted, in the order L->B->PE->L. The pointer advances only on an accepted grant.
REQ-022 Requesters keep valid and data stable until ready. The block never drops or duplicates a flit.
REQ-023 The block does not inspect flit header bits; routing decisions are made upstream.

Reset
REQ-024 While rstn=0: o_valid=0, o_data=0, FSM=EMPTY, pointer gives left the highest priority, o_grant=0.
REQ-025 Reset asserted mid-operation discards any held flit. The first grant after reset release follows REQ-024 priority.

Configuration
REQ-026 Macro NOC_ARB_RR_EN defined: round-robin per REQ-021.
REQ-027 Macro NOC_ARB_RR_EN undefined: fixed priority bottom > left > PE and no pointer register. REQ-014 to REQ-020 still apply.

Structure
REQ-028 Package noc_pkg holds:
- requester index constants REQ_L=0, REQ_B=1, REQ_PE=2, NUM_REQ=3;
- the FSM state enum (EMPTY, FULL);
- the flit-width function shared with the switches.
REQ-029 One sub-module, noc_rr_arbiter, takes the 3-bit request vector and the pointer. It is purely combinational and returns the one-hot grant. The top level holds the pointer, FSM and output register.

Verification
REQ-030 Reset, then L valid with data 0x2A5 and i_ready=1 -> o_ready_l=1 in cycle 0; o_valid=1 with o_data=0x2A5 in cycle 1; o_valid=0 in cycle 2.
REQ-031 L, B and PE all valid continuously, i_ready=1, RR build -> grant order L, B, PE, L, B, PE; six flits in six consecutive cycles.
REQ-032 Same stimulus as REQ-031, build without NOC_ARB_RR_EN -> B granted every cycle; L and PE see ready=0.
REQ-033 o_valid=1 with i_ready=0 for 4 cycles while L and PE are valid -> o_data stable, all ready=0. When i_ready rises, exactly one grant that cycle and the next flit appears one cycle later.
REQ-034 rstn pulsed low while o_valid=1 and i_ready=0 -> o_valid=0 asynchronously. After release, with all requesters valid, L is granted first.
REQ-035 Assertions across all scenarios:
- o_grant is one-hot or zero;
- no grant to a requester with valid=0;
- o_data is stable whenever o_valid & ~i_ready;
- the scoreboard shows no lost or duplicated flits.
